addsub_seq: RTL
===============

# addsub_seq

Multi-cycle WIDTH-bit adder/subtractor controller. It sequences a single SLICE-bit ripple add/sub slice (full-adder chain; operand B XORed with m; m used as initial carry-in) across the operand, least-significant slice first. Carry is chained between slices in a register. It produces the sum/difference, a signed-overflow flag and the carry-out, with a start/done handshake. It sits between the lab-level control logic and the shared add/sub datapath, so one narrow slice can serve wide operands.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, width of the internal add/sub slice; NSL = WIDTH/SLICE slices per operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- m  input  1  mode, captured on the accepting edge; 0 = A+B, 1 = A−B (two's complement).
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; out, v and c_out are valid in that cycle.
- out  output  WIDTH  result, registered.
- v  output  1  signed overflow = carry into MSB XOR carry out of MSB of the final slice.
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a, b and m; set slice counter cnt=0; set carry register cy=m; go to RUN.
  - RUN: slice k=cnt computes a[k*SLICE +: SLICE] + (b[...] ^ {SLICE{m}}) + cy. The SLICE result bits are written into the result shift register and cy is updated.
    - If cnt==NSL−1: load out from the assembled result, load c_out from the final slice carry, load v from the final slice carry-in-to-MSB XOR carry-out, then go to DONE.
    - Otherwise cnt++.
  - DONE: done=1. If start=1, latch new operands and go to RUN exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored; it is not queued.
- Operand changes on a, b or m after the accepting edge have no effect on the operation in flight.
- out, v and c_out change only on entry to DONE. They hold their values through IDLE and through the next RUN.
- Arithmetic is modulo 2^WIDTH. v and c_out describe the full WIDTH-bit operation, not an individual slice.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, cy=0, busy=0, done=0, out=0, v=0, c_out=0, internal operand and result registers 0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced. The first start after rst_n deasserts behaves normally.
- Latency:
  - start sampled high at edge E0.
  - busy=1 after E0 through edge E(NSL).
  - done=1 after E(NSL) for exactly one cycle.
  - Default parameters: 4 RUN cycles; done in cycle 5 after the accepting edge.
- Throughput: one operation per NSL+1 cycles with start held high continuously.
- busy and done are never high in the same cycle.
- Slice datapath is combinational within one cycle; the only carry path between slices is through cy.

## Test plan
- Add, default params: a=0x1234, b=0x0FFF, m=0, start pulsed one cycle.
  - Required: busy high for 4 cycles, then done pulse.
  - Required at done: out=0x2233, v=0, c_out=0.
- Full carry chain: a=0xFFFF, b=0x0001, m=0.
  - Required: out=0x0000, c_out=1, v=0 (carry propagates through all 4 slices via cy).
- Subtract and borrow:
  - 0x0000−0x0001 requires out=0xFFFF, v=0, c_out=0.
  - 0x0005−0x0003 requires out=0x0002, v=0, c_out=1.
- Signed overflow:
  - 0x7FFF+0x0001 requires out=0x8000, v=1, c_out=0.
  - 0x8000−0x0001 requires out=0x7FFF, v=1, c_out=1.
- Handshake:
  - start re-asserted during RUN with different operands: ignored; first result unchanged; no extra done.
  - start held high continuously: a new operation begins on the DONE edge, and done pulses every 5 cycles.
  - a and b changed mid-RUN: no effect on out.
- Reset mid-operation: rst_n pulled low asynchronously after the 2nd RUN cycle.
  - Required: immediately busy=0, done=0, out=0, v=0, c_out=0; no done pulse appears.
  - After release, start with 0x0001+0x0001 gives out=0x0002.

Source files
------------

// File: rtl/addsub_if.sv
// Start/done handshake and operand/result bus between the control logic and addsub_seq.
interface addsub_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             v;
  logic             c_out;

  modport master (output start, a, b, m, input busy, done, out, v, c_out);
  modport slave  (input start, a, b, m, output busy, done, out, v, c_out);
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/sub: one SLICE-bit ripple slice is reused LSB-first,
// with the inter-slice carry held in cy_q.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             m,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             c_msb,
  output logic             co
);
  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = x[i] ^ y[i] ^ m ^ c[i];
      c[i+1] = (x[i] & (y[i] ^ m)) | (c[i] & (x[i] ^ y[i] ^ m));
    end
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  addsub_if.slave  bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             v_q, v_d, c_out_q, c_out_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [SLICE-1:0] s_sum;
  logic             s_cmsb, s_co;

  // Operands shift right each RUN cycle, so the slice always sees the low bits.
  addsub_slice #(.SLICE(SLICE)) u_slice (
    .x     (a_q[SLICE-1:0]),
    .y     (b_q[SLICE-1:0]),
    .m     (m_q),
    .ci    (cy_q),
    .s     (s_sum),
    .c_msb (s_cmsb),
    .co    (s_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    out_d   = out_q;
    v_d     = v_q;
    c_out_d = c_out_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          m_d     = bus.m;
          cy_d    = bus.m;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        cy_d  = s_co;
        // Result fills from the top; after NSL slices slice 0 sits at the LSB.
        res_d = res_q >> SLICE;
        res_d[WIDTH-SLICE +: SLICE] = s_sum;
        if (cnt_q == LAST) begin
          out_d   = res_d;
          c_out_d = s_co;
          v_d     = s_cmsb ^ s_co;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      v_q     <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      out_q   <= out_d;
      v_q     <= v_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.v     = v_q;
  assign bus.c_out = c_out_q;
endmodule
